// File: rtl/router_reg_param_if.sv
// Bus between the router FSM/input port (master) and the packet register stage (slave).
interface router_reg_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 2
);
  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic              fifo_full;
  logic              rst_int_reg;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic [ADDR_W-1:0] hdr_addr;
  logic              hold_empty;
  logic              low_pkt_valid;
  logic              parity_done;
  logic              err;
  logic              len_err;
  logic              hold_ovf;

  modport master (
    output pkt_valid, data_in, fifo_full, rst_int_reg,
    output detect_add, lfd_state, ld_state, laf_state, full_state,
    input  dout, dout_valid, hdr_addr, hold_empty,
    input  low_pkt_valid, parity_done, err, len_err, hold_ovf
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, rst_int_reg,
    input  detect_add, lfd_state, ld_state, laf_state, full_state,
    output dout, dout_valid, hdr_addr, hold_empty,
    output low_pkt_valid, parity_done, err, len_err, hold_ovf
  );
endinterface

// File: rtl/router_reg_param.sv
// Router datapath register stage: header capture, FIFO write bus, hold buffer, parity check.
// Define ROUTER_REG_LEN_CHECK_EN to include the payload word counter and len_err.
module router_reg_param #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned HOLD_DEPTH = 2
) (
  input logic               clk_i,
  input logic               rst_i,
  router_reg_param_if.slave bus_io
);

  localparam int unsigned LenW = DATA_W - ADDR_W;
  localparam int unsigned CntW = $clog2(HOLD_DEPTH + 1);

  logic [DATA_W-1:0] header_q, header_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dv_q, dv_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] par_q, par_d;
  logic              lpv_q, lpv_d;
  logic              pd_q, pd_d;
  logic              pd_dly_q, pd_dly_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] hold_data_q [HOLD_DEPTH];
  logic [DATA_W-1:0] hold_data_d [HOLD_DEPTH];
  logic              hold_par_q  [HOLD_DEPTH];
  logic              hold_par_d  [HOLD_DEPTH];
  logic [CntW-1:0]   hold_cnt_q, hold_cnt_d;
`ifdef ROUTER_REG_LEN_CHECK_EN
  logic [LenW-1:0]   cnt_q, cnt_d;
  logic              len_err_q, len_err_d;
`endif

  logic hold_empty;
  assign hold_empty = (hold_cnt_q == '0);

  always_comb begin
    header_d   = header_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    dv_d       = 1'b0;
    acc_d      = acc_q;
    par_d      = par_q;
    lpv_d      = lpv_q;
    pd_d       = pd_q;
    pd_dly_d   = pd_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    hold_data_d = hold_data_q;
    hold_par_d  = hold_par_q;
    hold_cnt_d  = hold_cnt_q;
`ifdef ROUTER_REG_LEN_CHECK_EN
    cnt_d      = cnt_q;
    len_err_d  = len_err_q;
`endif

    if (bus_io.detect_add && bus_io.pkt_valid) begin
      header_d   = bus_io.data_in;
      addr_d     = bus_io.data_in[ADDR_W-1:0];
      acc_d      = '0;
      hold_cnt_d = '0;
      pd_d       = 1'b0;
      err_d      = 1'b0;
      ovf_d      = 1'b0;
`ifdef ROUTER_REG_LEN_CHECK_EN
      cnt_d      = '0;
      len_err_d  = 1'b0;
`endif
    end else begin
      // Checks fire once, the cycle after the parity word reached dout.
      if (pd_q && !pd_dly_q) begin
        err_d = err_q | (acc_q != par_q);
`ifdef ROUTER_REG_LEN_CHECK_EN
        len_err_d = len_err_q | (cnt_q != header_q[DATA_W-1:ADDR_W]);
`endif
      end
      if (bus_io.lfd_state) begin
        dout_d = header_q;
        dv_d   = 1'b1;
        acc_d  = acc_q ^ header_q;
      end else if (bus_io.ld_state) begin
        if (bus_io.pkt_valid) begin
          acc_d = acc_q ^ bus_io.data_in;
`ifdef ROUTER_REG_LEN_CHECK_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end else begin
          par_d = bus_io.data_in;
        end
        if (!bus_io.fifo_full && hold_empty) begin
          dout_d = bus_io.data_in;
          dv_d   = 1'b1;
          if (!bus_io.pkt_valid) pd_d = 1'b1;
        end else if (hold_cnt_q == CntW'(HOLD_DEPTH)) begin
          ovf_d = 1'b1;
        end else begin
          for (int i = 0; i < HOLD_DEPTH; i++) begin
            if (hold_cnt_q == CntW'(i)) begin
              hold_data_d[i] = bus_io.data_in;
              hold_par_d[i]  = !bus_io.pkt_valid;
            end
          end
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end else if (bus_io.laf_state && !bus_io.fifo_full && !hold_empty) begin
        dout_d = hold_data_q[0];
        dv_d   = 1'b1;
        if (hold_par_q[0]) pd_d = 1'b1;
        for (int i = 0; i < HOLD_DEPTH - 1; i++) begin
          hold_data_d[i] = hold_data_q[i+1];
          hold_par_d[i]  = hold_par_q[i+1];
        end
        hold_cnt_d = hold_cnt_q - 1'b1;
      end
    end

    if (bus_io.rst_int_reg) begin
      lpv_d = 1'b0;
    end else if (bus_io.ld_state && !bus_io.pkt_valid) begin
      lpv_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      header_q   <= '0;
      addr_q     <= '0;
      dout_q     <= '0;
      dv_q       <= 1'b0;
      acc_q      <= '0;
      par_q      <= '0;
      lpv_q      <= 1'b0;
      pd_q       <= 1'b0;
      pd_dly_q   <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      hold_cnt_q <= '0;
      for (int i = 0; i < HOLD_DEPTH; i++) begin
        hold_data_q[i] <= '0;
        hold_par_q[i]  <= 1'b0;
      end
`ifdef ROUTER_REG_LEN_CHECK_EN
      cnt_q      <= '0;
      len_err_q  <= 1'b0;
`endif
    end else begin
      header_q   <= header_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      dv_q       <= dv_d;
      acc_q      <= acc_d;
      par_q      <= par_d;
      lpv_q      <= lpv_d;
      pd_q       <= pd_d;
      pd_dly_q   <= pd_dly_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      hold_cnt_q <= hold_cnt_d;
      for (int i = 0; i < HOLD_DEPTH; i++) begin
        hold_data_q[i] <= hold_data_d[i];
        hold_par_q[i]  <= hold_par_d[i];
      end
`ifdef ROUTER_REG_LEN_CHECK_EN
      cnt_q      <= cnt_d;
      len_err_q  <= len_err_d;
`endif
    end
  end

  assign bus_io.dout          = dout_q;
  assign bus_io.dout_valid    = dv_q;
  assign bus_io.hdr_addr      = addr_q;
  assign bus_io.hold_empty    = hold_empty;
  assign bus_io.low_pkt_valid = lpv_q;
  assign bus_io.parity_done   = pd_q;
  assign bus_io.err           = err_q;
  assign bus_io.hold_ovf      = ovf_q;
`ifdef ROUTER_REG_LEN_CHECK_EN
  assign bus_io.len_err       = len_err_q;
`else
  assign bus_io.len_err       = 1'b0;
`endif

endmodule

// File: tb/tb_router_reg_param.sv
// Randomised bench for router_reg_param against a queue-based packet model.
module tb_router_reg_param;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;
  localparam int unsigned HD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  router_reg_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  router_reg_param #(.DATA_W(DW), .ADDR_W(AW), .HOLD_DEPTH(HD)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Packet-level model: expected register-visible state after each clock.
  logic [7:0] m_hdr, m_dout, m_acc, m_par;
  logic [1:0] m_addr;
  logic [5:0] m_cnt;
  logic       m_dv, m_pd, m_pd_prev, m_err, m_lerr, m_ovf, m_lpv;
  logic [8:0] m_q[$];

  task automatic model_reset();
    m_hdr = '0; m_dout = '0; m_acc = '0; m_par = '0; m_addr = '0; m_cnt = '0;
    m_dv = 0; m_pd = 0; m_pd_prev = 0; m_err = 0; m_lerr = 0; m_ovf = 0; m_lpv = 0;
    m_q.delete();
  endtask

  task automatic compare_all(input string ph);
    logic exp_len;
`ifdef ROUTER_REG_LEN_CHECK_EN
    exp_len = m_lerr;
`else
    exp_len = 1'b0;
`endif
    check_eq({ph, ".dout_valid"}, 32'(bus.dout_valid), 32'(m_dv));
    check_eq({ph, ".dout"}, 32'(bus.dout), 32'(m_dout));
    check_eq({ph, ".hdr_addr"}, 32'(bus.hdr_addr), 32'(m_addr));
    check_eq({ph, ".hold_empty"}, 32'(bus.hold_empty), 32'(m_q.size() == 0));
    check_eq({ph, ".low_pkt_valid"}, 32'(bus.low_pkt_valid), 32'(m_lpv));
    check_eq({ph, ".parity_done"}, 32'(bus.parity_done), 32'(m_pd));
    check_eq({ph, ".err"}, 32'(bus.err), 32'(m_err));
    check_eq({ph, ".len_err"}, 32'(bus.len_err), 32'(exp_len));
    check_eq({ph, ".hold_ovf"}, 32'(bus.hold_ovf), 32'(m_ovf));
  endtask

  task automatic step(input string ph, input logic da, input logic lfd, input logic ld,
                      input logic laf, input logic full, input logic pv, input logic [7:0] din,
                      input logic ff, input logic rir);
    logic       due;
    logic [8:0] e;
    bus.detect_add = da; bus.lfd_state = lfd; bus.ld_state = ld; bus.laf_state = laf;
    bus.full_state = full; bus.pkt_valid = pv; bus.data_in = din; bus.fifo_full = ff;
    bus.rst_int_reg = rir;
    due = m_pd && !m_pd_prev;
    m_pd_prev = m_pd;
    m_dv = 1'b0;
    if (da && pv) begin
      m_hdr = din; m_addr = din[1:0]; m_acc = '0; m_cnt = '0; m_q.delete();
      m_pd = 0; m_err = 0; m_lerr = 0; m_ovf = 0;
    end else begin
      if (due) begin
        if (m_acc != m_par) m_err = 1'b1;
        if (m_cnt != m_hdr[7:2]) m_lerr = 1'b1;
      end
      if (lfd) begin
        m_dout = m_hdr; m_dv = 1'b1; m_acc = m_acc ^ m_hdr;
      end else if (ld) begin
        if (pv) begin
          m_acc = m_acc ^ din; m_cnt = m_cnt + 6'd1;
        end else begin
          m_par = din;
        end
        if (!ff && m_q.size() == 0) begin
          m_dout = din; m_dv = 1'b1;
          if (!pv) m_pd = 1'b1;
        end else if (m_q.size() >= int'(HD)) begin
          m_ovf = 1'b1;
        end else begin
          m_q.push_back({!pv, din});
        end
      end else if (laf && !ff && m_q.size() > 0) begin
        e = m_q.pop_front();
        m_dout = e[7:0]; m_dv = 1'b1;
        if (e[8]) m_pd = 1'b1;
      end
    end
    if (rir) m_lpv = 1'b0;
    else if (ld && !pv) m_lpv = 1'b1;
    @(posedge clk);
    #1;
    compare_all(ph);
  endtask

  task automatic idle(input logic rir);
    step("idle", 0, 0, 0, 0, 0, 0, 8'($urandom), 1'($urandom), rir);
  endtask

  // ff_mask bit i gates payload word i; bit n gates the parity word.
  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] pl[$], input logic [7:0] par,
                          input logic [31:0] ff_mask, input logic rand_drain);
    int k;
    step("hdr", 1, 0, 0, 0, 0, 1, hdr, 0, 0);
    step("lfd", 0, 1, 0, 0, 0, 1, 8'($urandom), 0, 0);
    for (int i = 0; i < pl.size(); i++) begin
      if (rand_drain && ($urandom_range(0, 5) == 0))
        step("full", 0, 0, 0, 0, 1, 1'($urandom), 8'($urandom), 1, 0);
      step("pay", 0, 0, 1, 0, 0, 1, pl[i], ff_mask[i], 0);
    end
    step("par", 0, 0, 1, 0, 0, 0, par, ff_mask[pl.size()], 0);
    k = 0;
    while (m_q.size() > 0 && k < 60) begin
      step("laf", 0, 0, 0, 1, 0, 0, 8'($urandom), rand_drain ? ($urandom_range(0, 2) == 0) : 1'b0, 0);
      k++;
    end
    check_eq("drain_empty", 32'(bus.hold_empty), 32'd1);
    idle(1'b0);
    idle(1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    compare_all("reset");
    #2;
    rst = 1'b0;
  endtask

  function automatic logic [7:0] xor_all(input logic [7:0] hdr, input logic [7:0] pl[$]);
    logic [7:0] x;
    x = hdr;
    foreach (pl[i]) x = x ^ pl[i];
    return x;
  endfunction

  initial begin
    logic [7:0] pl[$];
    logic [7:0] hdr, par;
    int n, len;
    bus.detect_add = 0; bus.lfd_state = 0; bus.ld_state = 0; bus.laf_state = 0;
    bus.full_state = 0; bus.pkt_valid = 0; bus.data_in = '0; bus.fifo_full = 0;
    bus.rst_int_reg = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rst = 1'b0;

    pl = '{8'h11, 8'h22, 8'h33};
    send_pkt(8'h0D, pl, 8'h0D, 32'h0, 1'b0);
    check_eq("good.err", 32'(bus.err), 32'd0);
    send_pkt(8'h0D, pl, 8'h0E, 32'h0, 1'b0);
    check_eq("badpar.err", 32'(bus.err), 32'd1);
    pl = '{8'h11, 8'h22};
    send_pkt(8'h0D, pl, xor_all(8'h0D, pl), 32'h0, 1'b0);
    pl = '{8'h11, 8'h22, 8'h33};
    send_pkt(8'h0D, pl, 8'h0D, 32'h6, 1'b0);
    send_pkt(8'h0D, pl, 8'h0D, 32'hF, 1'b0);
    check_eq("ovf.hold_ovf", 32'(bus.hold_ovf), 32'd1);

    step("hdr", 1, 0, 0, 0, 0, 1, 8'h0D, 0, 0);
    step("lfd", 0, 1, 0, 0, 0, 1, 8'h00, 0, 0);
    step("pay", 0, 0, 1, 0, 0, 1, 8'h11, 0, 0);
    step("pay", 0, 0, 1, 0, 0, 1, 8'h22, 1, 0);
    do_reset();
    send_pkt(8'h0D, pl, 8'h0D, 32'h0, 1'b0);
    check_eq("post_reset.err", 32'(bus.err), 32'd0);

    for (int p = 0; p < 60; p++) begin
      len = $urandom_range(0, 6);
      hdr = {6'(len), 2'($urandom)};
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : len;
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      par = xor_all(hdr, pl);
      if ($urandom_range(0, 3) == 0) par = par ^ 8'($urandom_range(1, 255));
      send_pkt(hdr, pl, par, $urandom & $urandom, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
